// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and default operand width.
package mult_pkg;

   localparam int MULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/add_w_cout.sv
// WIDTH-bit unsigned adder with carry out; the carry is kept so the accumulate step is exact.
module add_w_cout #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/shift_add_multiplier8.sv
// Sequential unsigned shift-and-add multiplier: one adder pass per cycle, WIDTH cycles per product.
// Handshakes: a transfer occurs on a rising edge where valid && ready; valid never depends on ready.
module shift_add_multiplier8
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output state_t             dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [CW-1:0]      count_q, count_d;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               cout;

   // Low half of P holds the unconsumed multiplier bits; bit 0 selects this step's addend.
   assign addend = p_q[0] ? m_q : '0;

   add_w_cout #(.WIDTH(WIDTH)) u_add (
      .x    (p_q[2*WIDTH-1:WIDTH]),
      .y    (addend),
      .sum  (sum),
      .cout (cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         p_q     <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         p_q     <= p_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_d       = p_q;
      count_d   = count_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               m_d     = a;
               p_d     = {{WIDTH{1'b0}}, b};
               count_d = CW'(WIDTH);
               state_d = RUN;
            end
         end
         RUN: begin
            // Carry lands in the MSB so no product bit is ever lost.
            p_d     = {cout, sum, p_q[WIDTH-1:1]};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign product   = p_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_multiplier8.sv
// Bench for shift_add_multiplier8: vector table, multi-cycle corner sequences, random stream with scoreboard.
module tb_shift_add_multiplier8;
   import mult_pkg::*;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;
   state_t         dbg_state;

   int checks   = 0;
   int failures = 0;
   int out_count = 0;
   int cyc = 0;
   logic [2*W-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0]   va;
      logic [W-1:0]   vb;
      logic [2*W-1:0] vexp;
      int             stall;
      string          name;
   } vec_t;

   vec_t vecs[8];

   shift_add_multiplier8 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // scoreboard: push on input handshake, pop on output handshake
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
         end
         if (out_valid && out_ready) begin
            out_count++;
            check("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("sb_product", product, exp_q.pop_front());
         end
      end
   end

   // drivers
   task automatic wait_accept(input string nm, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_accept_in_time"}, (n < budget), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2*W-1:0] texp, input int stall, input string nm);
      int n;
      logic [2*W-1:0] held;
      @(posedge clk);
      #1;
      check({nm, "_ready_before"}, in_ready, 1);
      a = ta;
      b = tb_v;
      in_valid = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({nm, "_latency"}, n, 8);
      check({nm, "_product"}, product, texp);
      check({nm, "_busy_in_ready"}, in_ready, 0);
      held = product;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check({nm, "_stall_out_valid"}, out_valid, 1);
         check({nm, "_stall_in_ready"}, in_ready, 0);
         check({nm, "_stall_product"}, product, held);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({nm, "_after_in_ready"}, in_ready, 1);
      check({nm, "_after_out_valid"}, out_valid, 0);
   endtask

   initial begin
      int base;
      int acc_cyc[3];
      logic [W-1:0] sa[3];
      logic [W-1:0] sb[3];
      bit done;
      int n;

      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 0, "max_max"};
      vecs[1] = '{8'h00, 8'h5A, 16'h0000, 0, "zero_a"};
      vecs[2] = '{8'h80, 8'h02, 16'h0100, 0, "msb_times_2"};
      vecs[3] = '{8'h0D, 8'h0B, 16'h008F, 5, "stall5"};
      vecs[4] = '{8'hFF, 8'h00, 16'h0000, 0, "zero_b"};
      vecs[5] = '{8'h12, 8'h34, 16'h03A8, 2, "mid"};
      vecs[6] = '{8'h01, 8'hFF, 16'h00FF, 0, "one_a"};
      vecs[7] = '{8'hFF, 8'h01, 16'h00FF, 1, "one_b"};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_product", product, 0);
      check("reset_state", dbg_state, IDLE);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vexp, vecs[i].stall, vecs[i].name);
      end
      check("idle_keeps_last_product", product, 16'h00FF);

      // asynchronous reset in the middle of a run
      @(posedge clk);
      #1;
      a = 8'h37;
      b = 8'h2C;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check("pre_rst_state", dbg_state, RUN);
      rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_state", dbg_state, IDLE);
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_no_out_valid", out_valid, 0);
      end
      check("post_rst_queue_empty", exp_q.size(), 0);

      // back-to-back stream with in_valid held high
      sa = '{8'd3, 8'd255, 8'd16};
      sb = '{8'd5, 8'd1, 8'd16};
      base = out_count;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = sa[i];
         b = sb[i];
         wait_accept("stream", 40);
         acc_cyc[i] = cyc;
      end
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check("stream_drained", exp_q.size(), 0);
      check("stream_out_count", out_count - base, 3);
      check("stream_spacing_01", acc_cyc[1] - acc_cyc[0], 10);
      check("stream_spacing_12", acc_cyc[2] - acc_cyc[1], 10);

      // random operands with random output stalls
      base = out_count;
      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 1000; k++) begin
               a = W'($urandom_range(0, 255));
               b = W'($urandom_range(0, 255));
               in_valid = 1'b1;
               wait_accept("rand", 200);
               in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #2;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      check("rand_drained", exp_q.size(), 0);
      check("rand_out_count", out_count - base, 1000);
      check("final_state_idle", dbg_state, IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
